// File: rtl/bictr_dcnto_mode.sv
// Up/down binary counter with dynamic count-to compare and four terminal modes.
// Registered terminal-count and wrap pulses, plus a sticky one-shot done flag.
module bictr_dcnto_mode #(
    parameter int unsigned WIDTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             cen,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count_to,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             tc_pulse,
    output logic             wrap,
    output logic             done
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_STOP    = 2'b01;
    localparam logic [1:0] MODE_RELOAD  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step;
    logic             hit;
    logic             step_wraps;

    assign hit  = (count_q == count_to);
    assign step = up_dn ? count_q + 1'b1 : count_q - 1'b1;

    // Wrap is a property of the step itself, independent of mode.
    assign step_wraps = up_dn ? (count_q == ALL_ONES)
                              : (count_q == ALL_ZERO);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        tc_pulse_d = 1'b0;
        wrap_d     = 1'b0;

        if (!load) begin
            count_d    = data;
            state_d    = ST_COUNT;
            done_d     = 1'b0;
            tc_pulse_d = (data == count_to);
        end else if (state_q == ST_HOLD) begin
            count_d = count_q;
        end else if (cen) begin
            unique case (mode)
                MODE_WRAP: begin
                    count_d    = step;
                    wrap_d     = step_wraps;
                    tc_pulse_d = (step == count_to);
                end
                MODE_STOP: begin
                    if (!hit) begin
                        count_d    = step;
                        wrap_d     = step_wraps;
                        tc_pulse_d = (step == count_to);
                    end
                end
                MODE_RELOAD: begin
                    if (hit) begin
                        count_d    = data;
                        tc_pulse_d = (data == count_to);
                    end else begin
                        count_d    = step;
                        wrap_d     = step_wraps;
                        tc_pulse_d = (step == count_to);
                    end
                end
                MODE_ONESHOT: begin
                    if (hit) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        count_d    = step;
                        wrap_d     = step_wraps;
                        tc_pulse_d = (step == count_to);
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_COUNT;
            count_q    <= RST_VAL;
            tc_pulse_q <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tc_pulse_q <= tc_pulse_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    assign count    = count_q;
    assign tercnt   = hit;
    assign tc_pulse = tc_pulse_q;
    assign wrap     = wrap_q;
    assign done     = done_q;

endmodule
